// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N producers.
// Define UART_ARB_TIMEOUT_EN to compile in the START timeout and timeout_err.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic           sysclk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic [7:0]     tx_data,
  output logic           tx_start,
  input  logic           tx_status,
  output logic           busy,
  output logic [2:0]     grant_idx,
  output logic [15:0]    frame_count,
  output logic           timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    FRAME = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         sync1_q, sync2_q;
  logic         st_s;
  logic [2:0]   ptr_q, ptr_d;
  logic [N-1:0] ack_q, ack_d;
  logic [7:0]   data_q, data_d;
  logic [2:0]   gidx_q, gidx_d;
  logic [15:0]  frame_count_q, frame_count_d;
  logic         win_vld;
  logic [2:0]   win_idx;
  logic [7:0]   win_byte;
  logic         grant;
  logic         to_hit;

  // Ready resets high so a grant right after reset is not blocked.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= tx_status;
      sync2_q <= sync1_q;
    end
  end

  assign st_s = sync2_q;

  // Indices above ptr win first, then wrap around to 0..ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_vld && req[i] && 3'(i) > ptr_q) begin
        win_vld = 1'b1;
        win_idx = 3'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!win_vld && req[i] && 3'(i) <= ptr_q) begin
        win_vld = 1'b1;
        win_idx = 3'(i);
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == 3'(i)) win_byte = req_data[8*i +: 8];
    end
  end

  assign grant = (state_q == IDLE) && st_s && win_vld;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        terr_q, terr_d;

  assign to_hit = (cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    cnt_d  = (state_q == START) ? cnt_q + 16'd1 : 16'd0;
    terr_d = terr_q | ((state_q == START) && st_s && to_hit);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= 3'(N - 1);
      ack_q         <= '0;
      data_q        <= '0;
      gidx_q        <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      ack_q         <= ack_d;
      data_q        <= data_d;
      gidx_q        <= gidx_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant) state_d = START;
      end
      START: begin
        if (!st_s)       state_d = FRAME;
        else if (to_hit) state_d = IDLE;
      end
      FRAME: begin
        if (st_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d         = '0;
    data_d        = data_q;
    gidx_d        = gidx_q;
    ptr_d         = ptr_q;
    frame_count_d = frame_count_q;
    if (grant) begin
      for (int i = 0; i < N; i++) begin
        ack_d[i] = (win_idx == 3'(i));
      end
      data_d = win_byte;
      gidx_d = win_idx;
      ptr_d  = win_idx;
    end
    if (state_q == FRAME && st_s) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  assign ack         = ack_q;
  assign tx_data     = data_q;
  assign grant_idx   = gidx_q;
  assign frame_count = frame_count_q;
  assign tx_start    = (state_q == START);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random and directed stimulus for uart_tx_arbiter,
// checked against a round-robin reference model and a transmitter model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           sysclk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_status = 1'b1;
  logic           busy;
  logic [2:0]     grant_idx;
  logic [15:0]    frame_count;
  logic           timeout_err;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_status   (tx_status),
    .busy        (busy),
    .grant_idx   (grant_idx),
    .frame_count (frame_count),
    .timeout_err (timeout_err)
  );

  always #5 sysclk = ~sysclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Transmitter model: goes busy lat_cfg cycles after a start edge,
  // stays busy flen_cfg cycles, ignores starts while occupied.
  bit   mute      = 1'b0;
  bit   hold_busy = 1'b0;
  int   lat_cfg   = 2;
  int   flen_cfg  = 8;
  int   m_lat     = 0;
  int   m_busy    = 0;
  logic m_prev    = 1'b0;

  always @(negedge sysclk) begin
    if (m_busy > 0) m_busy--;
    if (m_lat > 0) begin
      m_lat--;
      if (m_lat == 0) m_busy = flen_cfg;
    end
    if (tx_start && !m_prev && !mute && m_lat == 0 && m_busy == 0)
      m_lat = lat_cfg;
    m_prev = tx_start;
    tx_status = !(hold_busy || m_busy > 0);
  end

  int          ref_ptr;
  logic [15:0] exp_fc;
  logic        exp_terr;
  logic [7:0]  bytes [N];

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    bytes[i] = v;
    req_data[8*i +: 8] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    req = '0;
    ref_ptr = N - 1;
    exp_fc = '0;
    exp_terr = 1'b0;
  endtask

  task automatic wait_ack(output int idx, output int lat, input int budget);
    idx = -1;
    lat = 0;
    while (lat < budget) begin
      step();
      lat++;
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) idx = i;
        chk("ack_onehot", 32'($onehot(ack)), 1);
        return;
      end
    end
    chk("ack_within_budget", 32'(|ack), 1);
  endtask

  // mode: 0 keep req, 1 drop granted req, 2 re-randomize everything
  task automatic do_grant(input bit ok, input int mode, output int lat);
    int want, idx, width, n;
    want = rr_pick(req, ref_ptr);
    wait_ack(idx, lat, 500);
    chk("ack_index", idx, want);
    chk("tx_data", tx_data, bytes[want]);
    chk("grant_idx", grant_idx, want);
    chk("tx_start_rise", tx_start, 1);
    ref_ptr = want;
    if (mode == 1) begin
      req[want] = 1'b0;
    end else if (mode == 2) begin
      for (int i = 0; i < N; i++) set_byte(i, 8'($urandom));
      req = N'($urandom_range(1, (1 << N) - 1));
      lat_cfg = $urandom_range(1, 4);
      flen_cfg = $urandom_range(1, 12);
    end
    width = 1;
    step();
    chk("ack_one_cycle", ack, 0);
    n = 0;
    while (busy && n < 2000) begin
      if (tx_start) width++;
      step();
      n++;
    end
    chk("back_to_idle", busy, 0);
    if (ok) begin
      exp_fc = exp_fc + 16'd1;
      chk("tx_start_min_width", 32'(width >= 3), 1);
    end else begin
      exp_terr = 1'b1;
      chk("tx_start_timeout_width", width, TO);
    end
    chk("frame_count", frame_count, exp_fc);
    chk("timeout_err", timeout_err, exp_terr);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, idx, n, bad;
    req = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) bytes[i] = '0;
    reset = 1'b1;
    step();
    step();
    chk("rst_ack", ack, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_timeout_err", timeout_err, 0);
    do_reset();

    // single request, immediate grant
    lat_cfg = 2;
    flen_cfg = 10;
    set_byte(0, 8'h55);
    req = 4'b0001;
    do_grant(1'b1, 1, lat);
    chk("grant_latency", lat, 1);

    // all requesting: strict rotation
    do_reset();
    for (int i = 0; i < N; i++) set_byte(i, 8'(8'hA0 + i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) do_grant(1'b1, 0, lat);
    req = '0;

    // transmitter busy at request time
    hold_busy = 1'b1;
    repeat (4) step();
    set_byte(1, 8'h3D);
    req = 4'b0010;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (ack != '0) bad++;
      step();
    end
    chk("no_ack_while_busy", bad, 0);
    hold_busy = 1'b0;
    do_grant(1'b1, 1, lat);

`ifdef UART_ARB_TIMEOUT_EN
    mute = 1'b1;
    set_byte(2, 8'hC2);
    req = 4'b0100;
    do_grant(1'b0, 1, lat);
    mute = 1'b0;
    set_byte(3, 8'hD3);
    req = 4'b1000;
    do_grant(1'b1, 1, lat);
`endif

    // reset while a frame is on the wire
    do_reset();
    lat_cfg = 1;
    flen_cfg = 60;
    set_byte(3, 8'h3C);
    req = 4'b1000;
    wait_ack(idx, lat, 50);
    chk("pre_reset_idx", idx, 3);
    req = '0;
    n = 0;
    while (tx_start && n < 200) begin
      step();
      n++;
    end
    chk("pre_reset_in_frame", busy, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_tx_start", tx_start, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tx_data", tx_data, 0);
    chk("async_rst_grant_idx", grant_idx, 0);
    chk("async_rst_frame_count", frame_count, 0);
    step();
    step();
    reset = 1'b0;
    ref_ptr = N - 1;
    exp_fc = '0;
    exp_terr = 1'b0;
    repeat (3) step();
    flen_cfg = 6;
    set_byte(1, 8'h71);
    req = 4'b0010;
    bad = 0;
    n = 0;
    while (!tx_status && n < 300) begin
      if (ack != '0) bad++;
      step();
      n++;
    end
    chk("no_grant_before_ready", bad, 0);
    do_grant(1'b1, 1, lat);

    // frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    step();
    release dut.frame_count_q;
    step();
    chk("frame_count_preload", frame_count, 16'hFFFF);
    exp_fc = 16'hFFFF;
    set_byte(0, 8'h0F);
    req = 4'b0001;
    lat_cfg = 1;
    flen_cfg = 3;
    do_grant(1'b1, 1, lat);

    // randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) set_byte(i, 8'($urandom));
    req = N'($urandom_range(1, (1 << N) - 1));
    for (int k = 0; k < 24; k++) do_grant(1'b1, 2, lat);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
